bru_pipe: RTL

BRU_PIPE -- requirements
Module: bru_pipe

---
 rtl/bru_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bru_pipe.sv
// bru_pipe: single-stage branch resolution unit with one output register.
// A request is resolved combinationally and captured into the output register
// on acceptance, so its result is visible one cycle later.
//
// Ports:
//   clock, reset (async, active-high), flush (kills held and in-flight result)
//   in_valid/in_ready     request handshake
//   in_funct, in_jal, in_jalr, in_src1, in_src2, in_pc, in_imm,
//   in_pred_taken, in_pred_target                         request payload
//   out_valid/out_ready   result handshake
//   out_taken, out_target, out_link, out_mispredict, out_illegal  result
//   stat_resolved, stat_mispredict  (only with BRU_PIPE_STAT_EN) saturating
//                                   counters of delivered results
//
// Optional feature macro: BRU_PIPE_STAT_EN
module bru_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRU_PIPE_STAT_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict
`endif
);

  logic            valid_q;
  logic            taken_q,   taken_d;
  logic [XLEN-1:0] target_q,  target_d;
  logic [XLEN-1:0] link_q,    link_d;
  logic            mispred_q, mispred_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            jump;
  logic            cond_taken;
  logic            funct_illegal;
  logic            eq;
  logic            ltu;
  logic            lts;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] jalr_sum;

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  // Unsigned less-than is the absence of carry out of src1 + ~src2 + 1.
  assign diff = {1'b0, in_src1} + {1'b0, ~in_src2} + {{XLEN{1'b0}}, 1'b1};
  assign eq   = (in_src1 == in_src2);
  assign ltu  = ~diff[XLEN];
  // Differing signs decide directly; equal signs reduce to the unsigned result.
  assign lts  = (in_src1[XLEN-1] != in_src2[XLEN-1]) ? in_src1[XLEN-1] : ltu;

  assign jump     = in_jal | in_jalr;
  assign pc_imm   = in_pc + in_imm;
  assign jalr_sum = in_src1 + in_imm;

  always_comb begin
    cond_taken    = 1'b0;
    funct_illegal = 1'b0;
    case (in_funct)
      3'b000:  cond_taken = eq;
      3'b001:  cond_taken = ~eq;
      3'b100:  cond_taken = lts;
      3'b101:  cond_taken = ~lts;
      3'b110:  cond_taken = ltu;
      3'b111:  cond_taken = ~ltu;
      default: funct_illegal = 1'b1;
    endcase
  end

  always_comb begin
    taken_d   = jump | cond_taken;
    illegal_d = ~jump & funct_illegal;
    link_d    = in_pc + XLEN'(4);
    if (in_jalr) begin
      target_d = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken_d) begin
      target_d = pc_imm;
    end else begin
      target_d = link_d;
    end
    mispred_d = (taken_d != in_pred_taken) |
                (taken_d & (target_d != in_pred_target));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      link_q    <= '0;
      mispred_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q   <= 1'b1;
        taken_q   <= taken_d;
        target_q  <= target_d;
        link_q    <= link_d;
        mispred_q <= mispred_d;
        illegal_q <= illegal_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_taken      = taken_q;
  assign out_target     = target_q;
  assign out_link       = link_q;
  assign out_mispredict = mispred_q;
  assign out_illegal    = illegal_q;

`ifdef BRU_PIPE_STAT_EN
  logic [31:0] stat_res_q;
  logic [31:0] stat_mis_q;
  logic        deliver;

  // A result killed by flush in the same cycle is not a delivered result.
  assign deliver = valid_q & out_ready & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else if (deliver) begin
      if (stat_res_q != '1) stat_res_q <= stat_res_q + 32'd1;
      if (mispred_q && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_resolved   = stat_res_q;
  assign stat_mispredict = stat_mis_q;
`endif

endmodule
